divider_bank_controller: RTL

//  Owns a bank of NUM_CH programmable clock-enable dividers running from one fabric clock.

---
 rtl/divider_bank_pkg.sv | 21 ++
 rtl/divider_bank_if.sv | 46 ++++
 rtl/divider_channel.sv | 115 +++++++++++
 rtl/divider_bank_controller.sv | 72 +++++++
 4 files changed

// File: rtl/divider_bank_pkg.sv
// Shared types and constants for the clock-enable divider bank.
// Imported by the config interface, the per-channel divider and the bank top.

package divider_bank_pkg;

   // Channel lifecycle: stopped, free-running, or running with a queued update.
   typedef enum logic [1:0] {
      OFF      = 2'd0,
      RUN      = 2'd1,
      RUN_PEND = 2'd2
   } ch_state_t;

   // Smallest divisor that still yields a wrap with a defined high/low phase.
   localparam int MIN_DIV = 2;

   // Width of a channel index; never narrower than one bit.
   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/divider_bank_if.sv
// Config write port and per-channel outputs of the divider bank.
// Handshake: a write transfers on a clock edge where cfg_valid && cfg_ready; the master holds
// cfg_ch/cfg_div/cfg_en stable while cfg_valid is high, and cfg_ready may depend on cfg_ch.

interface divider_bank_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 28
);

   localparam int IDX_W = divider_bank_pkg::ch_idx_w(NUM_CH);

   logic              cfg_valid;
   logic              cfg_ready;
   logic [IDX_W-1:0]  cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_en;
   logic              cfg_err;
   logic [NUM_CH-1:0] clock_out;
   logic [NUM_CH-1:0] tick_out;
   logic [NUM_CH-1:0] ch_active;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      output cfg_en,
      input  cfg_ready,
      input  cfg_err,
      input  clock_out,
      input  tick_out,
      input  ch_active
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      input  cfg_en,
      output cfg_ready,
      output cfg_err,
      output clock_out,
      output tick_out,
      output ch_active
   );

endinterface

// File: rtl/divider_channel.sv
// One programmable clock-enable divider: counter, divisor, queued update and glitch-free outputs.
// FSM state is visible through the active (state != OFF) and pend (state == RUN_PEND) outputs.

module divider_channel
   import divider_bank_pkg::*;
#(
   parameter int               CNT_W       = 28,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(50000000)
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   input  logic             wr_en,
   output logic             clock_out,
   output logic             tick_out,
   output logic             active,
   output logic             pend
);

   ch_state_t        state;
   ch_state_t        state_d;
   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] div_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] pend_div_q;
   logic [CNT_W-1:0] pend_div_d;
   logic             pend_en_q;
   logic             pend_en_d;
   logic             wrap;
   logic             clock_d;
   logic             tick_d;

   // State register; outputs are registered alongside so they never glitch.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state      <= OFF;
         div_q      <= DEFAULT_DIV;
         cnt_q      <= '0;
         pend_div_q <= DEFAULT_DIV;
         pend_en_q  <= 1'b0;
         clock_out  <= 1'b0;
         tick_out   <= 1'b0;
      end else begin
         state      <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         pend_div_q <= pend_div_d;
         pend_en_q  <= pend_en_d;
         clock_out  <= clock_d;
         tick_out   <= tick_d;
      end
   end

   // Next-state logic. The >= compare lets a counter stranded above a shorter divisor still wrap.
   always_comb begin
      state_d    = state;
      div_d      = div_q;
      cnt_d      = cnt_q;
      pend_div_d = pend_div_q;
      pend_en_d  = pend_en_q;
      wrap       = (state != OFF) && (cnt_q >= (div_q - CNT_W'(1)));

      case (state)
         OFF: begin
            cnt_d = '0;
            if (wr) begin
               div_d = wr_div;
               if (wr_en) begin
                  state_d = RUN;
               end
            end
         end

         RUN: begin
            cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));
            if (wr) begin
               pend_div_d = wr_div;
               pend_en_d  = wr_en;
               state_d    = RUN_PEND;
            end
         end

         RUN_PEND: begin
            cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));
            if (wrap) begin
               div_d   = pend_div_q;
               state_d = pend_en_q ? RUN : OFF;
            end
            // A write landing on the wrap edge queues behind the update being applied now.
            if (wr) begin
               pend_div_d = wr_div;
               pend_en_d  = wr_en;
               state_d    = RUN_PEND;
            end
         end

         default: begin
            state_d = OFF;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic: computed from next-cycle values so tick and the first high phase line up.
   always_comb begin
      clock_d = (state_d != OFF) && (cnt_d < (div_d >> 1));
      tick_d  = wrap && (state_d != OFF);
   end

   assign active = (state != OFF);
   assign pend   = (state == RUN_PEND);

endmodule

// File: rtl/divider_bank_controller.sv
// Bank of NUM_CH clock-enable dividers behind a single valid/ready config write port.
// Decodes and validates writes, steers them to one channel and reports rejected writes.

module divider_bank_controller
   import divider_bank_pkg::*;
#(
   parameter int               NUM_CH      = 4,
   parameter int               CNT_W       = 28,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(50000000)
) (
   input  logic         clock_in,
   input  logic         reset,
   divider_bank_if.slave cfg
);

   localparam int IDX_W = ch_idx_w(NUM_CH);

   logic              ch_ok;
   logic              div_ok;
   logic              accept;
   logic              wr_ok;
   logic              cfg_err_d;
   logic [NUM_CH-1:0] wr;
   logic [NUM_CH-1:0] pend;

   // A channel with an update already queued cannot take another until its wrap.
   always_comb begin
      cfg.cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pend[i] && (cfg.cfg_ch == IDX_W'(i))) begin
            cfg.cfg_ready = 1'b0;
         end
      end
   end

   // Invalid writes still complete the handshake so the master never stalls on them.
   always_comb begin
      ch_ok     = (int'(cfg.cfg_ch) < NUM_CH);
      div_ok    = (cfg.cfg_div >= CNT_W'(MIN_DIV));
      accept    = cfg.cfg_valid && cfg.cfg_ready;
      wr_ok     = accept && ch_ok && div_ok;
      cfg_err_d = accept && !(ch_ok && div_ok);
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         cfg.cfg_err <= 1'b0;
      end else begin
         cfg.cfg_err <= cfg_err_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr[i] = wr_ok && (cfg.cfg_ch == IDX_W'(i));

      divider_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_channel (
         .clock_in  (clock_in),
         .reset     (reset),
         .wr        (wr[i]),
         .wr_div    (cfg.cfg_div),
         .wr_en     (cfg.cfg_en),
         .clock_out (cfg.clock_out[i]),
         .tick_out  (cfg.tick_out[i]),
         .active    (cfg.ch_active[i]),
         .pend      (pend[i])
      );
   end

endmodule
